truth_table_sweeper: RTL

- Synthesizable, parametrised successor to our hand-written exhaustive 4-input stimulus benches.
- Drives every input combination of an N_IN-input combinational block pair, such as two candidate implementations of one function.
- Holds each vector for a programmable settle time, then compares the two outputs under a mask.
- Reports the pass/fail verdict, the mismatch count and the first failing vector. Sits beside the DUT pair in a bench or on-chip self-test wrapper.

---
 rtl/truth_table_sweeper_if.sv | 34 +++
 rtl/truth_table_sweeper.sv | 136 +++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper_if.sv
// Bundle between the sweeper and the harness that hosts the DUT pair.
// master drives control and DUT outputs; slave is the sweeper itself.
interface truth_table_sweeper_if #(
   parameter int N_IN  = 4,
   parameter int N_OUT = 1
);
   logic              start;
   logic              gray_mode;
   logic              stop_on_fail;
   logic [N_OUT-1:0]  out_mask;
   logic [N_OUT-1:0]  dut_a;
   logic [N_OUT-1:0]  dut_b;
   logic [N_IN-1:0]   vec_out;
   logic              busy;
   logic              done;
   logic              pass;
   logic [N_IN:0]     mismatch_count;
   logic [N_IN-1:0]   first_fail_vec;
   logic              fail_seen;

   modport master (
      output start, gray_mode, stop_on_fail, out_mask,
      output dut_a, dut_b,
      input  vec_out, busy, done, pass,
      input  mismatch_count, first_fail_vec, fail_seen
   );

   modport slave (
      input  start, gray_mode, stop_on_fail, out_mask,
      input  dut_a, dut_b,
      output vec_out, busy, done, pass,
      output mismatch_count, first_fail_vec, fail_seen
   );
endinterface

// File: rtl/truth_table_sweeper.sv
// Exhaustive input sweeper that compares two combinational DUTs.
// Binary or Gray order, per-vector settle time, masked compare.
module truth_table_sweeper #(
   parameter int N_IN        = 4,
   parameter int N_OUT       = 1,
   parameter int HOLD_CYCLES = 1
) (
   input  logic                 clk,
   input  logic                 reset,
   truth_table_sweeper_if.slave bus
);

   localparam int SW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [SW-1:0]   SETTLE_LOAD = SW'(HOLD_CYCLES - 1);
   localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
   localparam logic [N_IN:0]   LAST_IDX    = {1'b0, {N_IN{1'b1}}};
   localparam logic [N_IN:0]   ONE_W       = {{N_IN{1'b0}}, 1'b1};

   typedef enum logic [1:0] {
      S_IDLE,
      S_SETTLE,
      S_COMPARE,
      S_DONE
   } state_t;

   state_t            state_q, state_d;
   logic [N_IN:0]     idx_q, idx_d;
   logic [N_IN-1:0]   vec_q, vec_d;
   logic [SW-1:0]     settle_q, settle_d;
   logic [N_IN:0]     cnt_q, cnt_d;
   logic [N_IN-1:0]   ffv_q, ffv_d;
   logic              fail_q, fail_d;
   logic              gray_q, gray_d;
   logic              sof_q, sof_d;

   logic              mism;
   logic [N_IN:0]     nxt_idx;
   logic [N_IN-1:0]   nxt_bin;
   logic [N_IN-1:0]   nxt_gray;

   // Masked compare and next-vector candidates in both orders
   always_comb begin
      mism     = |((bus.dut_a ^ bus.dut_b) & bus.out_mask);
      nxt_idx  = idx_q + ONE_W;
      nxt_bin  = nxt_idx[N_IN-1:0];
      nxt_gray = nxt_bin ^ (nxt_bin >> 1);
   end

   // Sweep control: next state and next values of all registers
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      vec_d    = vec_q;
      settle_d = settle_q;
      cnt_d    = cnt_q;
      ffv_d    = ffv_q;
      fail_d   = fail_q;
      gray_d   = gray_q;
      sof_d    = sof_q;
      unique case (state_q)
         S_IDLE, S_DONE: begin
            if (bus.start) begin
               idx_d    = '0;
               vec_d    = '0;
               gray_d   = bus.gray_mode;
               sof_d    = bus.stop_on_fail;
               cnt_d    = '0;
               ffv_d    = '0;
               fail_d   = 1'b0;
               settle_d = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (settle_q == '0) begin
               state_d = S_COMPARE;
            end else begin
               settle_d = settle_q - SETTLE_ONE;
            end
         end
         S_COMPARE: begin
            if (mism) begin
               cnt_d = cnt_q + ONE_W;
               if (!fail_q) begin
                  fail_d = 1'b1;
                  ffv_d  = vec_q;
               end
            end
            if ((mism && sof_q) || (idx_q == LAST_IDX)) begin
               state_d = S_DONE;
            end else begin
               idx_d    = nxt_idx;
               vec_d    = gray_q ? nxt_gray : nxt_bin;
               settle_d = SETTLE_LOAD;
               state_d  = S_SETTLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers, cleared asynchronously
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= S_IDLE;
         idx_q    <= '0;
         vec_q    <= '0;
         settle_q <= '0;
         cnt_q    <= '0;
         ffv_q    <= '0;
         fail_q   <= 1'b0;
         gray_q   <= 1'b0;
         sof_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         vec_q    <= vec_d;
         settle_q <= settle_d;
         cnt_q    <= cnt_d;
         ffv_q    <= ffv_d;
         fail_q   <= fail_d;
         gray_q   <= gray_d;
         sof_q    <= sof_d;
      end
   end

   assign bus.vec_out        = vec_q;
   assign bus.busy           = (state_q == S_SETTLE) ||
                               (state_q == S_COMPARE);
   assign bus.done           = (state_q == S_DONE);
   assign bus.pass           = (state_q == S_DONE) && (cnt_q == '0);
   assign bus.mismatch_count = cnt_q;
   assign bus.first_fail_vec = ffv_q;
   assign bus.fail_seen      = fail_q;

endmodule
